// File: rtl/alu_bist_if.sv
// alu_bist_if: groups the BIST start/status and ALU drive/return signals.
// The master side is the BIST driver; the slave side is the ALU/test harness.
// Optional i_abort port is present only when ALU_BIST_ABORT_EN is defined.
interface alu_bist_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [WIDTH-1:0] i_alu_data;
`ifdef ALU_BIST_ABORT_EN
  logic             i_abort;
`endif
  logic [3:0]       o_alu_op;
  logic [WIDTH-1:0] o_operand_a;
  logic [WIDTH-1:0] o_operand_b;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [WIDTH-1:0] o_signature;

  modport master (
`ifdef ALU_BIST_ABORT_EN
    input  i_abort,
`endif
    input  i_start,
    input  i_alu_data,
    output o_alu_op,
    output o_operand_a,
    output o_operand_b,
    output o_busy,
    output o_done,
    output o_pass,
    output o_signature
  );

  modport slave (
`ifdef ALU_BIST_ABORT_EN
    output i_abort,
`endif
    output i_start,
    output i_alu_data,
    input  o_alu_op,
    input  o_operand_a,
    input  o_operand_b,
    input  o_busy,
    input  o_done,
    input  o_pass,
    input  o_signature
  );
endinterface

// File: rtl/alu_bist_driver.sv
// alu_bist_driver: BIST initiator for the RV32I ALU. Sweeps op codes
// 0..NUM_OPS-1, each over N_VECTORS LFSR operand pairs, folds every ALU
// result into a MISR and compares the final signature with GOLDEN_SIG.
// Optional feature macro: ALU_BIST_ABORT_EN (adds i_abort to stop a test).
module alu_bist_driver #(
  parameter int               WIDTH      = 32,
  parameter int               NUM_OPS    = 11,
  parameter int               N_VECTORS  = 64,
  parameter logic [WIDTH-1:0] LFSR_SEED  = WIDTH'(32'hACE1_2468),
  parameter logic [WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  alu_bist_if.master bus
);

  localparam logic [WIDTH-1:0] POLY     = WIDTH'(32'h8020_0003);
  localparam int               HALF     = WIDTH / 2;
  localparam int               VW       = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;
  localparam logic [VW-1:0]    VEC_LAST = VW'(N_VECTORS - 1);
  localparam logic [3:0]       OP_LAST  = 4'(NUM_OPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  // Galois right-shift LFSR step.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? POLY : '0);
  endfunction

  // Fold one ALU result into the left-shifting MISR.
  function automatic logic [WIDTH-1:0] misr_fold(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] data);
    return {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
  endfunction

  // Operand B is operand A rotated by half the word.
  function automatic logic [WIDTH-1:0] rot_half(input logic [WIDTH-1:0] v);
    return {v[HALF-1:0], v[WIDTH-1:HALF]};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [3:0]       op_cnt_q, op_cnt_d;
  logic [VW-1:0]    vec_cnt_q, vec_cnt_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] lfsr_nxt;

  assign lfsr_nxt = lfsr_step(lfsr_q);

  // Next-state and next-output logic; everything holds unless a state acts on it.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    op_cnt_d  = op_cnt_q;
    vec_cnt_d = vec_cnt_q;
    alu_op_d  = alu_op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sig_d     = sig_q;
    pass_d    = pass_q;
`ifdef ALU_BIST_ABORT_EN
    if (bus.i_abort && (state_q == RUN || state_q == CHECK)) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end else
`endif
    begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.i_start) begin
            state_d   = RUN;
            op_cnt_d  = '0;
            vec_cnt_d = '0;
            sig_d     = '0;
            lfsr_d    = LFSR_SEED;
            alu_op_d  = '0;
            opa_d     = LFSR_SEED;
            opb_d     = rot_half(LFSR_SEED);
            pass_d    = 1'b0;
          end
        end
        RUN: begin
          sig_d = misr_fold(sig_q, bus.i_alu_data);
          if (vec_cnt_q == VEC_LAST && op_cnt_q == OP_LAST) begin
            // Last sample: operands and op code stay on the final vector.
            state_d = CHECK;
          end else begin
            lfsr_d = lfsr_nxt;
            opa_d  = lfsr_nxt;
            opb_d  = rot_half(lfsr_nxt);
            if (vec_cnt_q == VEC_LAST) begin
              vec_cnt_d = '0;
              op_cnt_d  = op_cnt_q + 4'd1;
              alu_op_d  = op_cnt_q + 4'd1;
            end else begin
              vec_cnt_d = vec_cnt_q + VW'(1);
            end
          end
        end
        CHECK: begin
          pass_d  = (sig_q == GOLDEN_SIG);
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      op_cnt_q  <= '0;
      vec_cnt_q <= '0;
      alu_op_q  <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      sig_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      op_cnt_q  <= op_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      alu_op_q  <= alu_op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sig_q     <= sig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.o_alu_op    = alu_op_q;
  assign bus.o_operand_a = opa_q;
  assign bus.o_operand_b = opb_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_pass      = pass_q;
  assign bus.o_signature = sig_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// tb_alu_bist_driver: randomized bench for alu_bist_driver with a reference
// model of the operand stream, op sequencing and MISR signature.
module tb_alu_bist_driver;

  localparam int          NO   = 11;
  localparam int          NV   = 4;
  localparam int          M    = NO * NV;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] GOLD = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_bist_if #(.WIDTH(32)) bus  ();
  alu_bist_if #(.WIDTH(32)) bus2 ();

  alu_bist_driver #(.WIDTH(32), .NUM_OPS(NO), .N_VECTORS(NV),
                    .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD))
    dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  alu_bist_driver #(.WIDTH(32), .NUM_OPS(1), .N_VECTORS(1),
                    .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD))
    dut2 (.i_clk(clk), .i_reset(rst), .bus(bus2));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] lfsr_nxt(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ d;
  endfunction

  function automatic logic [31:0] rot16(input logic [31:0] v);
    return {v[15:0], v[31:16]};
  endfunction

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a << b[4:0];
      3:       return {31'b0, $signed(a) < $signed(b)};
      4:       return {31'b0, a < b};
      5:       return a ^ b;
      6:       return a >> b[4:0];
      7:       return $signed(a) >>> b[4:0];
      8:       return a | b;
      9:       return a & b;
      10:      return b;
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] vec_a [M];

  task automatic check_idle(input string tag);
    chk({tag, "_op"},   32'(bus.o_alu_op),  32'h0);
    chk({tag, "_a"},    bus.o_operand_a,    32'h0);
    chk({tag, "_b"},    bus.o_operand_b,    32'h0);
    chk({tag, "_busy"}, 32'(bus.o_busy),    32'h0);
    chk({tag, "_done"}, 32'(bus.o_done),    32'h0);
    chk({tag, "_pass"}, 32'(bus.o_pass),    32'h0);
    chk({tag, "_sig"},  bus.o_signature,    32'h0);
  endtask

  // mode: 0 zero ALU, 1 random data, 2 reference ALU, 3 single 1 then zeros
  task automatic sweep(input int mode, input int start_at, input int reset_at, input int abort_at);
    logic [31:0] sig;
    logic [31:0] d;
    int          op;
    sig = 32'h0;
    @(negedge clk) bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
    for (int k = 0; k < M; k++) begin
      op = k / NV;
      chk("run_busy", 32'(bus.o_busy), 32'h1);
      chk("run_done", 32'(bus.o_done), 32'h0);
      chk("run_op",   32'(bus.o_alu_op), 32'(op));
      chk("run_a",    bus.o_operand_a, vec_a[k]);
      chk("run_b",    bus.o_operand_b, rot16(vec_a[k]));
      chk("run_sig",  bus.o_signature, sig);
      case (mode)
        0:       d = 32'h0;
        1:       d = $urandom;
        2:       d = alu_ref(op, vec_a[k], rot16(vec_a[k]));
        default: d = (k == 0) ? 32'h1 : 32'h0;
      endcase
      bus.i_alu_data = d;
      if (k == start_at) bus.i_start = 1'b1;
      if (k == reset_at) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_idle("midrst");
        return;
      end
`ifdef ALU_BIST_ABORT_EN
      if (k == abort_at) begin
        bus.i_abort = 1'b1;
        @(posedge clk); #1 bus.i_abort = 1'b0;
        chk("abort_busy", 32'(bus.o_busy), 32'h0);
        chk("abort_done", 32'(bus.o_done), 32'h0);
        chk("abort_pass", 32'(bus.o_pass), 32'h0);
        chk("abort_sig",  bus.o_signature, sig);
        return;
      end
`endif
      @(posedge clk); #1 bus.i_start = 1'b0;
      sig = misr(sig, d);
    end
    chk("chk_busy", 32'(bus.o_busy), 32'h1);
    chk("chk_done", 32'(bus.o_done), 32'h0);
    chk("chk_sig",  bus.o_signature, sig);
    @(posedge clk); #1;
    chk("done_busy", 32'(bus.o_busy), 32'h0);
    chk("done_done", 32'(bus.o_done), 32'h1);
    chk("done_pass", 32'(bus.o_pass), 32'(sig == GOLD));
    chk("done_sig",  bus.o_signature, sig);
    chk("done_op",   32'(bus.o_alu_op), 32'(NO - 1));
    chk("done_a",    bus.o_operand_a, vec_a[M-1]);
    if (abort_at < 0) begin
      @(posedge clk); #1;
      chk("hold_done", 32'(bus.o_done), 32'h1);
    end
  endtask

  initial begin
    logic [31:0] v;
    v = SEED;
    for (int k = 0; k < M; k++) begin
      vec_a[k] = v;
      v = lfsr_nxt(v);
    end

    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_alu_data = 32'h0;
    bus2.i_start = 1'b0;
    bus2.i_alu_data = 32'h0;
`ifdef ALU_BIST_ABORT_EN
    bus.i_abort = 1'b0;
    bus2.i_abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset2_sig", bus2.o_signature, 32'h0);
    rst = 1'b0;

    sweep(0, -1, -1, -1);
    sweep(2, -1, -1, -1);
    sweep(1, -1, -1, -1);
    sweep(3, -1, -1, -1);
    sweep(1, 5, 10, -1);
    repeat (3) @(posedge clk);
    #1 check_idle("idle_after_rst");
    sweep(2, -1, -1, -1);
`ifdef ALU_BIST_ABORT_EN
    sweep(1, -1, -1, 3);
    chk("abort_idle_done", 32'(bus.o_done), 32'h0);
    sweep(2, -1, -1, -1);
`endif

    @(negedge clk) bus2.i_start = 1'b1;
    @(posedge clk); #1 bus2.i_start = 1'b0;
    chk("m1_busy", 32'(bus2.o_busy), 32'h1);
    chk("m1_a", bus2.o_operand_a, SEED);
    chk("m1_b", bus2.o_operand_b, 32'h2468_ACE1);
    bus2.i_alu_data = 32'h1;
    @(posedge clk); #1 bus2.i_alu_data = 32'h0;
    chk("m1_chk_busy", 32'(bus2.o_busy), 32'h1);
    chk("m1_chk_sig", bus2.o_signature, 32'h1);
    @(posedge clk); #1;
    chk("m1_done", 32'(bus2.o_done), 32'h1);
    chk("m1_pass", 32'(bus2.o_pass), 32'h0);
    chk("m1_sig", bus2.o_signature, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
